// File: rtl/scs_pkg.sv
// Shared definitions for the weighted simple checksum (SCS) generator and checker.
package scs_pkg;

   localparam int SCS_LEN_ADDR_LO = 4;
   localparam int SCS_LEN_ADDR_HI = 5;
   localparam int SCS_MIN_LEN     = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_RESULT = 2'd2,
      ST_LENERR = 2'd3
   } scs_state_e;

   // Weighted term: byte zero-extended to 16 bits, shifted by address mod 4.
   function automatic logic [15:0] scs_term(input logic [7:0] data_byte,
                                            input logic [1:0] addr_lsb);
      logic [15:0] term;
      case (addr_lsb)
         2'd0:    term = {8'd0, data_byte};
         2'd1:    term = {7'd0, data_byte, 1'b0};
         2'd2:    term = {6'd0, data_byte, 2'd0};
         2'd3:    term = {5'd0, data_byte, 3'd0};
         default: term = 16'd0;
      endcase
      return term;
   endfunction

endpackage

// File: rtl/scs_check_if.sv
// RAM read port plus control/result bus between packet controller and SCS checker.
interface scs_check_if #(
   parameter int RAM_WIDTH     = 8,
   parameter int RAM_ADDR_BITS = 10
);
   logic                     start;
   logic                     mem_ready;
   logic [RAM_ADDR_BITS-1:0] address;
   logic [RAM_WIDTH-1:0]     mem_output;
   logic                     busy;
   logic                     done;
   logic                     pass;
   logic                     len_err;
   logic [15:0]              calc_sum;
   logic [15:0]              rx_sum;

   modport master (
      output start, mem_ready, mem_output,
      input  address, busy, done, pass, len_err, calc_sum, rx_sum
   );

   modport slave (
      input  start, mem_ready, mem_output,
      output address, busy, done, pass, len_err, calc_sum, rx_sum
   );
endinterface

// File: rtl/scs_accum.sv
// 16-bit weighted accumulator: adds byte << (addr mod 4), wrapping mod 2^16.
module scs_accum
   import scs_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic [7:0]  data_byte,
   input  logic [1:0]  addr_lsb,
   output logic [15:0] sum
);
   logic [15:0] sum_r;

   // Running sum; clear wins over enable so a new check starts from zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         sum_r <= 16'd0;
      end else if (clear) begin
         sum_r <= 16'd0;
      end else if (enable) begin
         sum_r <= sum_r + scs_term(data_byte, addr_lsb);
      end else begin
         sum_r <= sum_r;
      end
   end

   assign sum = sum_r;
endmodule

// File: rtl/scs_check.sv
// SCS receive-side checker: streams the packet from RAM, recomputes the
// weighted sum over bytes 0..L-1 and compares it with the stored sum at L/L+1.
module scs_check
   import scs_pkg::*;
#(
   parameter int RAM_WIDTH     = 8,
   parameter int RAM_ADDR_BITS = 10
) (
   input logic        clock,
   input logic        reset,
   scs_check_if.slave bus
);
   localparam int          ADDR_PAD = 16 - RAM_ADDR_BITS;
   localparam logic [15:0] MAX_LEN  = 16'((32'd1 << RAM_ADDR_BITS) - 32'd2);
   localparam logic [15:0] HDR_LAST = 16'd7;

   scs_state_e               state_r, state_s;
   logic [RAM_ADDR_BITS-1:0] address_r, addr_d1_r;
   logic                     iss_v_r, cap_v_r;
   logic [15:0]              len_r, rx_sum_r, calc_sum_s;
   logic                     len_known_r;
   logic                     busy_r, done_r, pass_r, len_err_r;
   logic [RAM_WIDTH-1:0]     data_s;
   logic [15:0]              issue_addr_s, cap_addr_s, len_cand_s, len_p1_s;
   logic                     accept_s, cap_s, len_ok_s, incr_s;
   logic                     acc_en_s, rx_lo_s, rx_hi_s, len_lo_s, len_hi_s;

   assign data_s = bus.mem_output;

   // Decode: start acceptance, routing of the captured byte, address advance.
   always_comb begin
      issue_addr_s = {{ADDR_PAD{1'b0}}, address_r};
      cap_addr_s   = {{ADDR_PAD{1'b0}}, addr_d1_r};
      len_cand_s   = {data_s[7:0], len_r[7:0]};
      len_p1_s     = len_r + 16'd1;
      accept_s     = (state_r == ST_IDLE) && bus.start && bus.mem_ready;
      cap_s        = (state_r == ST_FETCH) && cap_v_r;
      len_ok_s     = (len_cand_s >= 16'(SCS_MIN_LEN)) && (len_cand_s <= MAX_LEN);
      acc_en_s     = 1'b0;
      rx_lo_s      = 1'b0;
      rx_hi_s      = 1'b0;
      len_lo_s     = 1'b0;
      len_hi_s     = 1'b0;
      if (cap_s) begin
         len_lo_s = (cap_addr_s == 16'(SCS_LEN_ADDR_LO));
         len_hi_s = (cap_addr_s == 16'(SCS_LEN_ADDR_HI));
         // Header bytes are summed before L is known; legal L is at least 6.
         if ((cap_addr_s < 16'(SCS_MIN_LEN)) || (cap_addr_s < len_r)) begin
            acc_en_s = 1'b1;
         end else if (cap_addr_s == len_r) begin
            rx_lo_s = 1'b1;
         end else if (cap_addr_s == len_p1_s) begin
            rx_hi_s = 1'b1;
         end else begin
            acc_en_s = 1'b0;
         end
      end else begin
         acc_en_s = 1'b0;
      end
      // Addresses 0..7 are issued unconditionally, then up to L+1 once L is known.
      incr_s = (state_r == ST_FETCH) &&
               ((issue_addr_s < HDR_LAST) || (len_known_r && (issue_addr_s < len_p1_s)));
   end

   // Next-state logic of the check sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_s = ST_FETCH;
            else          state_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (len_hi_s && !len_ok_s) state_s = ST_LENERR;
            else if (rx_hi_s)          state_s = ST_RESULT;
            else                       state_s = ST_FETCH;
         end
         ST_RESULT: state_s = ST_IDLE;
         ST_LENERR: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clock) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_s;
   end

   // Address generator: restarts at 0 on accept, holds at its last value when finished.
   always_ff @(posedge clock) begin
      if (reset) begin
         address_r <= '0;
         iss_v_r   <= 1'b0;
      end else if (accept_s) begin
         address_r <= '0;
         iss_v_r   <= 1'b1;
      end else if (incr_s) begin
         address_r <= address_r + 1'b1;
         iss_v_r   <= 1'b1;
      end else begin
         address_r <= address_r;
         iss_v_r   <= 1'b0;
      end
   end

   // Address copy aligned with the RAM read data (one RAM register stage).
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_d1_r <= '0;
         cap_v_r   <= 1'b0;
      end else begin
         addr_d1_r <= address_r;
         cap_v_r   <= iss_v_r;
      end
   end

   // Length field capture from header bytes 4 (low) and 5 (high).
   always_ff @(posedge clock) begin
      if (reset || accept_s) begin
         len_r       <= 16'd0;
         len_known_r <= 1'b0;
      end else if (len_lo_s) begin
         len_r[7:0]  <= data_s[7:0];
         len_known_r <= 1'b0;
      end else if (len_hi_s) begin
         len_r[15:8] <= data_s[7:0];
         len_known_r <= 1'b1;
      end else begin
         len_r       <= len_r;
         len_known_r <= len_known_r;
      end
   end

   // Stored checksum capture from addresses L and L+1.
   always_ff @(posedge clock) begin
      if (reset || accept_s) begin
         rx_sum_r <= 16'd0;
      end else if (rx_lo_s) begin
         rx_sum_r[7:0] <= data_s[7:0];
      end else if (rx_hi_s) begin
         rx_sum_r[15:8] <= data_s[7:0];
      end else begin
         rx_sum_r <= rx_sum_r;
      end
   end

   // Status outputs: busy until done, one-cycle done, held pass/len_err.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
         len_err_r <= 1'b0;
      end else if (accept_s) begin
         busy_r    <= 1'b1;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
         len_err_r <= 1'b0;
      end else if (state_r == ST_RESULT) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b1;
         pass_r    <= (calc_sum_s == rx_sum_r);
         len_err_r <= 1'b0;
      end else if (state_r == ST_LENERR) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b1;
         pass_r    <= 1'b0;
         len_err_r <= 1'b1;
      end else begin
         busy_r    <= busy_r;
         done_r    <= 1'b0;
         pass_r    <= pass_r;
         len_err_r <= len_err_r;
      end
   end

   scs_accum u_accum (
      .clock     (clock),
      .reset     (reset),
      .clear     (accept_s),
      .enable    (acc_en_s),
      .data_byte (data_s[7:0]),
      .addr_lsb  (addr_d1_r[1:0]),
      .sum       (calc_sum_s)
   );

   assign bus.address  = address_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.pass     = pass_r;
   assign bus.len_err  = len_err_r;
   assign bus.calc_sum = calc_sum_s;
   assign bus.rx_sum   = rx_sum_r;
endmodule

// File: tb/tb_scs_check.sv
// Directed self-checking bench for scs_check with a behavioural synchronous RAM.
module tb_scs_check;
   import scs_pkg::*;

   logic clock;
   logic reset;
   logic [7:0] ram [0:1023];

   int n_checks;
   int n_pass;
   int lat, ndone, max_addr;
   logic le_d, ps_d, busy_seen;

   scs_check_if #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) bus ();

   scs_check #(.RAM_WIDTH(8), .RAM_ADDR_BITS(10)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-port synchronous RAM read: data valid the cycle after address is sampled.
   always @(posedge clock) begin
      bus.mem_output <= ram[bus.address];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic load_min(input logic [7:0] b7);
      ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
      ram[4] = 8'h06; ram[5] = 8'h00; ram[6] = 8'h37; ram[7] = b7;
   endtask

   // Accepting edge is k; returns #1 after edge k.
   task automatic do_start();
      @(negedge clock);
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
   endtask

   // Observe budget cycles after edge k; optionally pulse start before edge pulse_at.
   task automatic run_window(input int budget, input int pulse_at);
      lat = -1; ndone = 0; max_addr = 0; le_d = 1'b0; ps_d = 1'b0; busy_seen = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         if (c == pulse_at) bus.start = 1'b1;
         @(posedge clock);
         #1;
         bus.start = 1'b0;
         if (bus.done) begin
            ndone++;
            if (lat < 0) begin
               lat  = c;
               le_d = bus.len_err;
               ps_d = bus.pass;
            end
         end
         if (bus.busy) busy_seen = 1'b1;
         if (int'(bus.address) > max_addr) max_addr = int'(bus.address);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_address",  32'(bus.address),  32'h0);
      check_val("rst_busy",     32'(bus.busy),     32'h0);
      check_val("rst_done",     32'(bus.done),     32'h0);
      check_val("rst_pass",     32'(bus.pass),     32'h0);
      check_val("rst_len_err",  32'(bus.len_err),  32'h0);
      check_val("rst_calc_sum", 32'(bus.calc_sum), 32'h0);
      check_val("rst_rx_sum",   32'(bus.rx_sum),   32'h0);
      reset = 1'b0;

      // Minimum packet
      load_min(8'h00);
      do_start();
      check_val("min_busy_k", 32'(bus.busy), 32'h1);
      run_window(14, 0);
      check_val("min_latency",  32'(lat),          32'd10);
      check_val("min_ndone",    32'(ndone),        32'd1);
      check_val("min_pass_d",   32'(ps_d),         32'h1);
      check_val("min_calc_sum", 32'(bus.calc_sum), 32'h0037);
      check_val("min_rx_sum",   32'(bus.rx_sum),   32'h0037);
      check_val("min_busy_end", 32'(bus.busy),     32'h0);
      check_val("min_max_addr", 32'(max_addr),     32'd7);

      // Mismatch
      load_min(8'h01);
      do_start();
      check_val("mis_pass_clr", 32'(bus.pass), 32'h0);
      run_window(14, 0);
      check_val("mis_latency",  32'(lat),          32'd10);
      check_val("mis_pass_d",   32'(ps_d),         32'h0);
      check_val("mis_len_err",  32'(le_d),         32'h0);
      check_val("mis_calc_sum", 32'(bus.calc_sum), 32'h0037);
      check_val("mis_rx_sum",   32'(bus.rx_sum),   32'h0137);

      // Length error (L = 5)
      load_min(8'h00);
      ram[4] = 8'h05;
      do_start();
      run_window(13, 0);
      check_val("len_latency",  32'(lat),      32'd8);
      check_val("len_err_d",    32'(le_d),     32'h1);
      check_val("len_pass_d",   32'(ps_d),     32'h0);
      check_val("len_ndone",    32'(ndone),    32'd1);
      check_val("len_max_addr", 32'(max_addr), 32'd7);

      // Wrap-around: L = 1022
      for (int i = 0; i < 1022; i++) ram[i] = 8'hFF;
      ram[4] = 8'hFE; ram[5] = 8'h03; ram[1022] = 8'h13; ram[1023] = 8'hE3;
      do_start();
      run_window(1030, 0);
      check_val("wrap_latency",  32'(lat),          32'd1026);
      check_val("wrap_pass_d",   32'(ps_d),         32'h1);
      check_val("wrap_calc_sum", 32'(bus.calc_sum), 32'hE313);
      check_val("wrap_rx_sum",   32'(bus.rx_sum),   32'hE313);
      check_val("wrap_max_addr", 32'(max_addr),     32'd1023);

      // Start while busy is ignored
      load_min(8'h00);
      do_start();
      run_window(20, 3);
      check_val("busy_latency", 32'(lat),   32'd10);
      check_val("busy_ndone",   32'(ndone), 32'd1);
      check_val("busy_pass_d",  32'(ps_d),  32'h1);

      // Start with mem_ready low is ignored
      bus.mem_ready = 1'b0;
      do_start();
      run_window(15, 0);
      bus.mem_ready = 1'b1;
      check_val("nrdy_ndone", 32'(ndone),     32'd0);
      check_val("nrdy_busy",  32'(busy_seen), 32'h0);
      check_val("nrdy_pass",  32'(bus.pass),  32'h1);

      // Reset at k+5 aborts the check
      do_start();
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_val("abort_address",  32'(bus.address),  32'h0);
      check_val("abort_busy",     32'(bus.busy),     32'h0);
      check_val("abort_done",     32'(bus.done),     32'h0);
      check_val("abort_calc_sum", 32'(bus.calc_sum), 32'h0);
      check_val("abort_rx_sum",   32'(bus.rx_sum),   32'h0);
      reset = 1'b0;
      run_window(15, 0);
      check_val("abort_ndone", 32'(ndone), 32'd0);

      // Fresh start after the abort
      do_start();
      run_window(14, 0);
      check_val("fresh_latency",  32'(lat),          32'd10);
      check_val("fresh_pass_d",   32'(ps_d),         32'h1);
      check_val("fresh_calc_sum", 32'(bus.calc_sum), 32'h0037);
      check_val("fresh_rx_sum",   32'(bus.rx_sum),   32'h0037);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
